dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/chronos_pkg.sv | 12 +
 rtl/dmem_array.sv | 19 +
 rtl/dmem_responder.sv | 87 ++++++++
 tb/tb_dmem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/chronos_pkg.sv
// chronos_pkg: request width codes, responder FSM states and type helpers
package chronos_pkg;
    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b100;
    localparam logic [2:0] TYPE_HU = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    function automatic logic type_legal(input logic [2:0] t);
        return t inside {TYPE_B, TYPE_H, TYPE_W, TYPE_BU, TYPE_HU};
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-addressed storage with byte-enable synchronous write and combinational read
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory responder; DMEM_MISALIGN_CHECK_EN faults misaligned accesses
module dmem_responder
    import chronos_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t state, state_nx;
    logic [3:0] cnt;
    logic lat_write, lat_err;
    logic [2:0] lat_type;
    logic [31:0] lat_addr, lat_wdata, rd_word, sh, load_data, wlanes;
    logic accept, is_half, is_word, misal, err, we;
    logic [1:0] eff_lo;
    logic [3:0] be;
    logic unused_bits;
    assign accept = req_valid & req_ready;
    assign is_half = req_type[1:0] == 2'b01;
    assign is_word = req_type[1:0] == 2'b10;
    assign misal = (is_half & req_addr[0]) | (is_word & |req_addr[1:0]);
`ifdef DMEM_MISALIGN_CHECK_EN
    assign err = !type_legal(req_type) | misal;
    assign eff_lo = req_addr[1:0];
`else
    assign err = !type_legal(req_type);
    assign eff_lo = is_word ? 2'b00 : is_half ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif
    assign be = is_word ? 4'b1111 : is_half ? (eff_lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << eff_lo;
    assign wlanes = is_word ? req_wdata : is_half ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
    // Stores commit on the accept edge, so a following load always sees them
    assign we = accept & req_write & !err;
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk(clk),
        .we(we),
        .be(be),
        .waddr(req_addr[AW+1:2]),
        .wdata(wlanes),
        .raddr(lat_addr[AW+1:2]),
        .rdata(rd_word)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= accept ? 4'(LATENCY - 1) : state == ST_WAIT ? cnt - 4'd1 : cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_type <= req_type;
            lat_addr <= {req_addr[31:2], eff_lo};
            lat_wdata <= req_wdata;
            lat_err <= err;
        end
    end
    always_comb
        state_nx = state == ST_IDLE ? (accept ? (LATENCY == 1 ? ST_RESP : ST_WAIT) : ST_IDLE)
                 : state == ST_WAIT ? (cnt == 4'd1 ? ST_RESP : ST_WAIT)
                 : ST_IDLE;
    assign sh = rd_word >> {lat_addr[1:0], 3'b000};
    assign load_data = lat_type[1:0] == 2'b10 ? sh
                     : lat_type[1:0] == 2'b01 ? {{16{~lat_type[2] & sh[15]}}, sh[15:0]}
                     : {{24{~lat_type[2] & sh[7]}}, sh[7:0]};
    always_comb begin
        req_ready = state == ST_IDLE && rst;
        resp_valid = state == ST_RESP && rst;
        resp_err = resp_valid & lat_err;
        resp_rdata = resp_valid && !lat_err && !lat_write ? load_data : 32'd0;
    end
    assign unused_bits = ^{lat_wdata, lat_addr[31:AW+2]};
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder
module tb_dmem_responder;
    localparam int LAT = 2;
    logic clk = 0, rst = 0, req_valid = 0, req_write = 0;
    logic [2:0] req_type = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    int cyc = 0, checks = 0, failures = 0;
    typedef struct {string name; logic [31:0] rdata; logic err; int cyc;} exp_t;
    exp_t sb[$];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_type(req_type), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end else begin
            chk("idle_zero", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'd0);
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout: got req_ready=0 expected 1", name);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_resp_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input string name, input logic w, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic e);
        req_valid = 1; req_write = w; req_type = t; req_addr = a; req_wdata = d;
        wait_ready(name);
        sb.push_back('{name, er, e, cyc + LAT});
        @(negedge clk);
        req_valid = 0;
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        rst = 1;
        @(negedge clk);
        issue("sw_10",   1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        issue("lw_10",   0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        issue("lb_13",   0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
        issue("lbu_13",  0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0);
        issue("lh_12",   0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
        issue("lhu_10",  0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0);
        issue("sb_11",   1, 3'b000, 32'h11, 32'h12, 32'h0, 0);
        issue("lw_10b",  0, 3'b010, 32'h10, 32'h0, 32'hDEAD12EF, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        issue("lw_12mis", 0, 3'b010, 32'h12, 32'h0, 32'h0, 1);
        issue("lh_11mis", 0, 3'b001, 32'h11, 32'h0, 32'h0, 1);
        issue("sw_11mis", 1, 3'b010, 32'h11, 32'h55555555, 32'h0, 1);
`else
        issue("lw_12mis", 0, 3'b010, 32'h12, 32'h0, 32'hDEAD12EF, 0);
        issue("lh_11mis", 0, 3'b001, 32'h11, 32'h0, 32'h000012EF, 0);
        issue("sw_11mis", 1, 3'b010, 32'h11, 32'hDEAD12EF, 32'h0, 0);
`endif
        issue("lw_10c",  0, 3'b010, 32'h10, 32'h0, 32'hDEAD12EF, 0);
        issue("st_ill",  1, 3'b011, 32'h10, 32'h0, 32'h0, 1);
        issue("ld_ill",  0, 3'b110, 32'h10, 32'h0, 32'h0, 1);
        issue("lw_10d",  0, 3'b010, 32'h10, 32'h0, 32'hDEAD12EF, 0);
        issue("sw_14",   1, 3'b010, 32'h14, 32'h11223344, 32'h0, 0);
        issue("sh_16",   1, 3'b001, 32'h16, 32'h9876ABCD, 32'h0, 0);
        issue("lw_14",   0, 3'b010, 32'h14, 32'h0, 32'hABCD3344, 0);
        issue("lb_14",   0, 3'b000, 32'h14, 32'h0, 32'h00000044, 0);
        issue("lh_16",   0, 3'b001, 32'h16, 32'h0, 32'hFFFFABCD, 0);
        // request held through WAIT must not be accepted twice
        req_valid = 1; req_write = 0; req_type = 3'b100; req_addr = 32'h10;
        wait_ready("held");
        sb.push_back('{"held", 32'h000000EF, 1'b0, cyc + LAT});
        @(negedge clk);
        chk("held_ready_wait", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        req_valid = 0;
        drain("held");
        repeat (4) @(negedge clk);
        // reset during WAIT drops the load
        req_valid = 1; req_write = 0; req_type = 3'b010; req_addr = 32'h10;
        wait_ready("rstmid");
        @(negedge clk);
        req_valid = 0;
        rst = 0;
        @(negedge clk);
        chk("rstmid_ready_low", {31'd0, req_ready}, 32'd0);
        chk("rstmid_valid_low", {31'd0, resp_valid}, 32'd0);
        rst = 1;
        @(negedge clk);
        chk("rstmid_ready_back", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        issue("lw_10e",  0, 3'b010, 32'h10, 32'h0, 32'hDEAD12EF, 0);
        issue("sw_1000", 1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 0);
        issue("lw_0",    0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
